// File: rtl/code_lock_ctrl.sv
// Keypad combination-lock controller: collects four hex digits, checks them against a
// stored code, handles code replacement while unlocked and a timed lockout after repeated failures.
module code_lock_ctrl #(
    parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
    parameter int          MAX_FAILS      = 3,
    parameter int          LOCKOUT_CYCLES = 100_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_value,
    input  logic       key_enter,
    input  logic       key_clear,
    output logic [3:0] hex1,
    output logic [3:0] hex2,
    output logic [3:0] hex3,
    output logic [3:0] hex4,
    output logic [2:0] digit_count,
    output logic       enter,
    output logic       unlock,
    output logic       lock,
    output logic       locked_out,
    output logic [2:0] fail_count
);

    localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    code_q, code_d;
    // hex_q[3] is the first digit, so the packed vector lines up with the stored code
    logic [3:0][3:0] hex_q, hex_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [2:0]     fail_q, fail_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           enter_q, enter_d;
    logic           unlock_q, unlock_d;
    logic           lock_q, lock_d;
    logic           locked_out_q, locked_out_d;
    logic [3:0]     fail_inc;

    assign fail_inc = {1'b0, fail_q} + 4'd1;

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        hex_d    = hex_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        timer_d  = timer_q;
        enter_d  = 1'b0;
        unlock_d = 1'b0;
        lock_d   = 1'b0;

        case (state_q)
            ST_LOCKOUT: begin
                hex_d = '0;
                cnt_d = '0;
                if (timer_q == '0) begin
                    state_d = ST_ENTRY;
                    fail_d  = '0;
                    enter_d = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                if (key_clear) begin
                    hex_d   = '0;
                    cnt_d   = '0;
                    enter_d = 1'b1;
                end else if (key_enter) begin
                    if (state_q == ST_UNLOCKED) begin
                        if (cnt_q == 3'd0) begin
                            state_d = ST_ENTRY;
                            enter_d = 1'b1;
                        end else if (cnt_q == 3'd4) begin
                            code_d  = hex_q;
                            state_d = ST_ENTRY;
                            hex_d   = '0;
                            cnt_d   = '0;
                            enter_d = 1'b1;
                        end
                    end else if (cnt_q == 3'd4) begin
                        hex_d = '0;
                        cnt_d = '0;
                        if (hex_q == code_q) begin
                            state_d  = ST_UNLOCKED;
                            fail_d   = '0;
                            unlock_d = 1'b1;
                        end else if (fail_inc < 4'(MAX_FAILS)) begin
                            fail_d  = fail_inc[2:0];
                            enter_d = 1'b1;
                        end else begin
                            // timer counts LOCKOUT_CYCLES-1 down to 0, then one exit cycle
                            fail_d  = 3'(MAX_FAILS);
                            state_d = ST_LOCKOUT;
                            lock_d  = 1'b1;
                            timer_d = TW'(LOCKOUT_CYCLES - 1);
                        end
                    end
                end else if (key_valid && cnt_q < 3'd4) begin
                    hex_d[2'd3 - cnt_q[1:0]] = key_value;
                    cnt_d = cnt_q + 3'd1;
                end
            end
        endcase

        locked_out_d = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_ENTRY;
            code_q       <= DEFAULT_CODE;
            hex_q        <= '0;
            cnt_q        <= '0;
            fail_q       <= '0;
            timer_q      <= '0;
            enter_q      <= 1'b0;
            unlock_q     <= 1'b0;
            lock_q       <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            hex_q        <= hex_d;
            cnt_q        <= cnt_d;
            fail_q       <= fail_d;
            timer_q      <= timer_d;
            enter_q      <= enter_d;
            unlock_q     <= unlock_d;
            lock_q       <= lock_d;
            locked_out_q <= locked_out_d;
        end
    end

    assign hex1        = hex_q[3];
    assign hex2        = hex_q[2];
    assign hex3        = hex_q[1];
    assign hex4        = hex_q[0];
    assign digit_count = cnt_q;
    assign fail_count  = fail_q;
    assign enter       = enter_q;
    assign unlock      = unlock_q;
    assign lock        = lock_q;
    assign locked_out  = locked_out_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl: a per-cycle vector table for the entry/unlock/code-change
// flows, plus hand-written sequences for lockout timing and reset mid-operation.
module tb_code_lock_ctrl;

    localparam logic [15:0] DEF_CODE = 16'h1234;
    localparam int          MAXF     = 3;
    localparam int          LCYC     = 8;

    localparam logic [3:0] P_NONE = 4'b0000;  // {enter, unlock, lock, locked_out}
    localparam logic [3:0] P_EN   = 4'b1000;
    localparam logic [3:0] P_UN   = 4'b0100;
    localparam logic [3:0] P_LK   = 4'b0011;
    localparam logic [3:0] P_LO   = 4'b0001;

    typedef struct packed {
        logic [15:0] hx;
        logic [2:0]  cnt;
        logic [3:0]  pul;
        logic [2:0]  fail;
    } out_t;

    typedef struct packed {
        logic       c;
        logic       e;
        logic       v;
        logic [3:0] val;
        out_t       exp;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_value = '0;
    logic       key_enter = 1'b0;
    logic       key_clear = 1'b0;
    logic [3:0] hex1, hex2, hex3, hex4;
    logic [2:0] digit_count, fail_count;
    logic       enter, unlock, lock, locked_out;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];

    code_lock_ctrl #(.DEFAULT_CODE(DEF_CODE), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LCYC)) dut (
        .clock(clock), .reset(reset),
        .key_valid(key_valid), .key_value(key_value),
        .key_enter(key_enter), .key_clear(key_clear),
        .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4),
        .digit_count(digit_count),
        .enter(enter), .unlock(unlock), .lock(lock), .locked_out(locked_out),
        .fail_count(fail_count)
    );

    always #5 clock = ~clock;

    function automatic out_t eo(logic [15:0] hx, logic [2:0] cnt, logic [3:0] pul, logic [2:0] fail);
        out_t o;
        o.hx = hx; o.cnt = cnt; o.pul = pul; o.fail = fail;
        return o;
    endfunction

    function automatic vec_t mk(logic c, logic e, logic v, logic [3:0] val,
                                logic [15:0] hx, logic [2:0] cnt, logic [3:0] pul, logic [2:0] fail);
        vec_t r;
        r.c = c; r.e = e; r.v = v; r.val = val;
        r.exp = eo(hx, cnt, pul, fail);
        return r;
    endfunction

    // drive strobes for one edge, then sample 1 time unit after it
    task automatic step(input logic c, input logic e, input logic v, input logic [3:0] val);
        key_clear = c; key_enter = e; key_valid = v; key_value = val;
        @(posedge clock);
        #1;
        key_clear = 1'b0; key_enter = 1'b0; key_valid = 1'b0; key_value = '0;
    endtask

    task automatic chk(input string name, input out_t exp);
        out_t act;
        act.hx   = {hex1, hex2, hex3, hex4};
        act.cnt  = digit_count;
        act.pul  = {enter, unlock, lock, locked_out};
        act.fail = fail_count;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got hex=%h cnt=%0d pulses=%b fail=%0d, expected hex=%h cnt=%0d pulses=%b fail=%0d",
                     name, act.hx, act.cnt, act.pul, act.fail, exp.hx, exp.cnt, exp.pul, exp.fail);
        end
    endtask

    task automatic type4(input string name, input logic [15:0] code, input logic [2:0] fail);
        logic [15:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask = 16'hFFFF;
            mask = ~(mask >> (4 * (i + 1)));
            step(1'b0, 1'b0, 1'b1, code[15 - 4*i -: 4]);
            chk($sformatf("%s_d%0d", name, i + 1), eo(code & mask, 3'(i + 1), P_NONE, fail));
        end
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk(name, eo(16'h0, 3'd0, P_NONE, 3'd0));
    endtask

    initial begin
        // main flows, one record per cycle
        tbl.push_back(mk(0,0,1,4'h1, 16'h1000,1,P_NONE,0));
        tbl.push_back(mk(0,0,1,4'h2, 16'h1200,2,P_NONE,0));
        tbl.push_back(mk(0,0,1,4'h3, 16'h1230,3,P_NONE,0));
        tbl.push_back(mk(0,0,1,4'h4, 16'h1234,4,P_NONE,0));
        tbl.push_back(mk(0,0,1,4'h5, 16'h1234,4,P_NONE,0)); // fifth digit ignored
        tbl.push_back(mk(0,1,0,4'h0, 16'h0000,0,P_UN,  0)); // default code unlocks
        tbl.push_back(mk(0,0,0,4'h0, 16'h0000,0,P_NONE,0));
        tbl.push_back(mk(0,0,1,4'hA, 16'hA000,1,P_NONE,0));
        tbl.push_back(mk(0,0,1,4'hB, 16'hAB00,2,P_NONE,0));
        tbl.push_back(mk(0,1,0,4'h0, 16'hAB00,2,P_NONE,0)); // partial code ignored while unlocked
        tbl.push_back(mk(0,0,1,4'hC, 16'hABC0,3,P_NONE,0));
        tbl.push_back(mk(0,0,1,4'hD, 16'hABCD,4,P_NONE,0));
        tbl.push_back(mk(0,1,0,4'h0, 16'h0000,0,P_EN,  0)); // new code ABCD stored
        tbl.push_back(mk(0,0,1,4'h1, 16'h1000,1,P_NONE,0));
        tbl.push_back(mk(0,0,1,4'h2, 16'h1200,2,P_NONE,0));
        tbl.push_back(mk(0,0,1,4'h3, 16'h1230,3,P_NONE,0));
        tbl.push_back(mk(0,0,1,4'h4, 16'h1234,4,P_NONE,0));
        tbl.push_back(mk(0,1,0,4'h0, 16'h0000,0,P_EN,  1)); // old code now wrong
        tbl.push_back(mk(0,0,1,4'hA, 16'hA000,1,P_NONE,1));
        tbl.push_back(mk(0,0,1,4'hB, 16'hAB00,2,P_NONE,1));
        tbl.push_back(mk(0,0,1,4'hC, 16'hABC0,3,P_NONE,1));
        tbl.push_back(mk(0,0,1,4'hD, 16'hABCD,4,P_NONE,1));
        tbl.push_back(mk(0,1,0,4'h0, 16'h0000,0,P_UN,  0));
        tbl.push_back(mk(0,1,0,4'h0, 16'h0000,0,P_EN,  0)); // relock, no digits
        tbl.push_back(mk(0,0,1,4'h7, 16'h7000,1,P_NONE,0));
        tbl.push_back(mk(0,0,1,4'h8, 16'h7800,2,P_NONE,0));
        tbl.push_back(mk(0,1,0,4'h0, 16'h7800,2,P_NONE,0)); // short code ignored
        tbl.push_back(mk(1,0,0,4'h0, 16'h0000,0,P_EN,  0));
        tbl.push_back(mk(0,0,1,4'hA, 16'hA000,1,P_NONE,0));
        tbl.push_back(mk(0,0,1,4'hB, 16'hAB00,2,P_NONE,0));
        tbl.push_back(mk(0,0,1,4'hC, 16'hABC0,3,P_NONE,0));
        tbl.push_back(mk(0,0,1,4'hD, 16'hABCD,4,P_NONE,0));
        tbl.push_back(mk(1,1,1,4'h5, 16'h0000,0,P_EN,  0)); // clear wins over enter/valid
        tbl.push_back(mk(0,1,0,4'h0, 16'h0000,0,P_NONE,0)); // enter with no digits
        tbl.push_back(mk(0,1,1,4'h9, 16'h0000,0,P_NONE,0)); // enter wins, valid dropped

        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset_state", eo(16'h0, 3'd0, P_NONE, 3'd0));

        foreach (tbl[i]) begin
            step(tbl[i].c, tbl[i].e, tbl[i].v, tbl[i].val);
            chk($sformatf("vec%0d", i), tbl[i].exp);
        end

        // lockout timing: three wrong attempts, keys ignored, exit exactly LCYC cycles after lock
        type4("lo_a1", 16'h5555, 3'd0);
        step(0, 1, 0, 4'h0);
        chk("lo_fail1", eo(16'h0, 3'd0, P_EN, 3'd1));
        type4("lo_a2", 16'h5555, 3'd1);
        step(0, 1, 0, 4'h0);
        chk("lo_fail2", eo(16'h0, 3'd0, P_EN, 3'd2));
        type4("lo_a3", 16'h5555, 3'd2);
        step(0, 1, 0, 4'h0);
        chk("lo_lock", eo(16'h0, 3'd0, P_LK, 3'd3));
        for (int k = 1; k < LCYC; k++) begin
            step(k % 3 == 0, k % 3 == 1, 1'b1, 4'(k));
            chk($sformatf("lo_hold%0d", k), eo(16'h0, 3'd0, P_LO, 3'd3));
        end
        step(0, 0, 1, 4'hA);
        chk("lo_exit", eo(16'h0, 3'd0, P_EN, 3'd0));
        step(0, 0, 0, 4'h0);
        chk("lo_after", eo(16'h0, 3'd0, P_NONE, 3'd0));

        // reset mid-lockout restores the default code
        for (int a = 0; a < MAXF; a++) begin
            type4($sformatf("rl_a%0d", a), 16'h0F0F, 3'(a));
            step(0, 1, 0, 4'h0);
            chk($sformatf("rl_e%0d", a), eo(16'h0, 3'd0, (a == MAXF - 1) ? P_LK : P_EN, 3'(a + 1)));
        end
        step(0, 0, 0, 4'h0);
        step(0, 0, 0, 4'h0);
        chk("rl_mid", eo(16'h0, 3'd0, P_LO, 3'd3));
        do_reset("rl_reset");
        type4("rl_def", DEF_CODE, 3'd0);
        step(0, 1, 0, 4'h0);
        chk("rl_unlock", eo(16'h0, 3'd0, P_UN, 3'd0));

        // reset in UNLOCKED after a code change
        type4("ru_new", 16'h9999, 3'd0);
        step(0, 1, 0, 4'h0);
        chk("ru_store", eo(16'h0, 3'd0, P_EN, 3'd0));
        type4("ru_use", 16'h9999, 3'd0);
        step(0, 1, 0, 4'h0);
        chk("ru_unlock", eo(16'h0, 3'd0, P_UN, 3'd0));
        step(0, 0, 1, 4'h5);
        chk("ru_digit", eo(16'h5000, 3'd1, P_NONE, 3'd0));
        do_reset("ru_reset");
        type4("ru_def", DEF_CODE, 3'd0);
        step(0, 1, 0, 4'h0);
        chk("ru_def_unlock", eo(16'h0, 3'd0, P_UN, 3'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Combination-lock controller that turns debounced keypad events into the four code digits and the enter/lock/unlock event pulses consumed by the lock's seven-segment display driver. It collects up to four hex digits, checks them against a stored 16-bit code, and tracks failed attempts with a timed lockout. While unlocked it also accepts a replacement code. It sits between the keypad debouncer and the display driver.

## Interface
Parameters:
- DEFAULT_CODE, 16'h1234, code loaded at reset; digit 1 is bits [15:12], digit 4 is bits [3:0]
- MAX_FAILS, 3, consecutive wrong codes that trigger lockout (1..7)
- LOCKOUT_CYCLES, 100_000_000, lockout duration in clock cycles (>= 1)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe; key_value is a digit entry
- key_value  in  4  hex digit 0-F
- key_enter  in  1  one-cycle strobe; submit or relock
- key_clear  in  1  one-cycle strobe; discard digits entered so far
- hex1..hex4  out  4 each  entered digits, first to fourth; unentered digits read 0
- digit_count  out  3  number of digits entered (0..4)
- enter  out  1  one-cycle pulse; lock returned to or stayed in initial/entry state
- unlock  out  1  one-cycle pulse; correct code accepted
- lock  out  1  one-cycle pulse; lockout started
- locked_out  out  1  level, high while in LOCKOUT
- fail_count  out  3  consecutive failed attempts

## Operation
- States: ENTRY (reset state), UNLOCKED, LOCKOUT.
- Per-cycle input priority is key_clear > key_enter > key_valid. At most one event is processed per cycle, and lower-priority strobes in the same cycle are dropped.
- Digit entry (ENTRY and UNLOCKED):
  - key_valid with digit_count < 4 writes key_value into hex(digit_count+1), then digit_count increments.
  - key_valid with digit_count == 4 is ignored.
- key_clear (ENTRY and UNLOCKED): hex1..hex4 go to 0 and digit_count to 0; the state is unchanged; enter pulses.
- key_enter in ENTRY:
  - digit_count < 4: ignored, no pulse.
  - Digits equal the stored code: go to UNLOCKED, pulse unlock, fail_count = 0, clear digits.
  - Mismatch and fail_count+1 < MAX_FAILS: fail_count increments, stay in ENTRY, clear digits, pulse enter.
  - Mismatch and fail_count+1 == MAX_FAILS: fail_count = MAX_FAILS, go to LOCKOUT, pulse lock, clear digits, load the lockout timer.
- key_enter in UNLOCKED:
  - digit_count == 0: relock; go to ENTRY and pulse enter. The code is unchanged.
  - digit_count == 4: the stored code becomes {hex1,hex2,hex3,hex4}; go to ENTRY, clear digits, pulse enter.
  - digit_count 1..3: ignored.
- LOCKOUT:
  - All key strobes are ignored and digits stay 0.
  - The timer counts down each cycle. At expiry: go to ENTRY, fail_count = 0, pulse enter.
- The stored code changes only through reset or the UNLOCKED write path.
- At most one of enter/unlock/lock is high in any cycle.

## Timing
- All outputs are registered. A strobe sampled at edge N is reflected in the outputs after edge N, i.e. visible during cycle N+1.
- Event pulses are exactly one cycle wide.
- Lockout: lock is high in cycle L. locked_out is high for cycles L .. L+LOCKOUT_CYCLES-1. enter pulses in cycle L+LOCKOUT_CYCLES, when locked_out returns low.
- Reset is synchronous and overrides everything, including mid-lockout and mid-entry. After reset:
  - state ENTRY, stored code = DEFAULT_CODE;
  - hex1..hex4 = 0, digit_count = 0, fail_count = 0;
  - enter, unlock, lock, locked_out = 0;
  - lockout timer = 0.
- Back-to-back key_valid strobes on consecutive cycles are each accepted.

## Test plan
- Reset, then key digits 1,2,3,4 and key_enter -> hex1..4 = 1,2,3,4 with digit_count = 4 before enter; unlock pulses once the cycle after enter; digits = 0 and fail_count = 0 afterwards.
- Enter 5,5,5,5 three times with MAX_FAILS = 3 -> enter pulses after attempts 1 and 2 with fail_count 1 then 2. Attempt 3 pulses lock and sets locked_out. Keys during lockout are ignored. With LOCKOUT_CYCLES = 8, enter pulses exactly 8 cycles after lock, with fail_count = 0.
- Unlock with 1234, key A,B,C,D and enter -> enter pulses. Then 1,2,3,4 + enter gives enter (fail_count = 1), and A,B,C,D + enter gives unlock.
- Key 7,8 then key_enter -> no pulse, digit_count stays 2. Then key_clear -> enter pulses, digits cleared. Key a fifth digit after four -> ignored, hex4 unchanged.
- Same-cycle key_clear + key_enter + key_valid with 4 correct digits entered -> only the clear takes effect: enter pulses, no unlock, digit_count = 0.
- Assert reset during lockout with the timer mid-count, and again in UNLOCKED after a code change -> all outputs reach their reset values the next cycle, and the stored code returns to DEFAULT_CODE (1234 then unlocks).
